// File: rtl/seg_scan_reader.sv
// Reads a multiplexed active-low 7-segment display scan and rebuilds the 4-digit BCD value.
// A digit is accepted once its pattern is stable; complete in-order frames update bcd.
module seg_scan_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  digit_en,
   input  logic [7:0]  segments,
   output logic [15:0] bcd,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        seq_err
);

   localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {StSync, StCollect, StEmit} state_e;

   state_e      state_q, state_d;
   logic [3:0]  en_q, en_prev_q;
   logic [6:0]  seg_q, seg_prev_q;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] slots_q, slots_d;
   logic [1:0]  nidx_q, nidx_d;
   logic        err_q, err_d;
   logic [15:0] bcd_d;
   logic        frame_valid_d, frame_err_d, seq_err_d;

   logic        one_hot, same, accept, store, restart;
   logic [1:0]  idx;
   logic [3:0]  nib;
   logic        nib_bad;
   logic        unused_seg7;

   assign unused_seg7 = segments[7];

   assign one_hot = (en_q != 4'b0000) && ((en_q & (en_q - 4'd1)) == 4'b0000);
   assign same    = (en_q == en_prev_q) && (seg_q == seg_prev_q);
   assign accept  = one_hot && same && (cnt_q == StableMax - 4'd1);

   always_comb begin
      case (en_q)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

   always_comb begin
      nib_bad = 1'b0;
      case (seg_q)
         7'h40:   nib = 4'd0;
         7'h79:   nib = 4'd1;
         7'h24:   nib = 4'd2;
         7'h30:   nib = 4'd3;
         7'h19:   nib = 4'd4;
         7'h12:   nib = 4'd5;
         7'h02:   nib = 4'd6;
         7'h78:   nib = 4'd7;
         7'h00:   nib = 4'd8;
         7'h10:   nib = 4'd9;
         default: begin
            nib     = 4'hF;
            nib_bad = 1'b1;
         end
      endcase
   end

   // Blanking (zero or multi-hot select) parks the counter at 0.
   always_comb begin
      if (!one_hot) begin
         cnt_d = 4'd0;
      end else if (!same) begin
         cnt_d = 4'd1;
      end else if (cnt_q < StableMax) begin
         cnt_d = cnt_q + 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StSync;
         en_q        <= '0;
         en_prev_q   <= '0;
         seg_q       <= '0;
         seg_prev_q  <= '0;
         cnt_q       <= '0;
         slots_q     <= '0;
         nidx_q      <= '0;
         err_q       <= 1'b0;
         bcd         <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         seq_err     <= 1'b0;
      end else begin
         state_q     <= state_d;
         en_q        <= digit_en;
         en_prev_q   <= en_q;
         seg_q       <= segments[6:0];
         seg_prev_q  <= seg_q;
         cnt_q       <= cnt_d;
         slots_q     <= slots_d;
         nidx_q      <= nidx_d;
         err_q       <= err_d;
         bcd         <= bcd_d;
         frame_valid <= frame_valid_d;
         frame_err   <= frame_err_d;
         seq_err     <= seq_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StSync: begin
            if (accept && idx == 2'd0) state_d = StCollect;
         end
         StCollect: begin
            if (accept) begin
               if (idx == nidx_q) begin
                  state_d = (idx == 2'd3) ? StEmit : StCollect;
               end else if (idx == 2'd0) begin
                  state_d = StCollect;
               end else begin
                  state_d = StSync;
               end
            end
         end
         StEmit:  state_d = StSync;
         default: state_d = StSync;
      endcase
   end

   always_comb begin
      slots_d       = slots_q;
      nidx_d        = nidx_q;
      err_d         = err_q;
      bcd_d         = bcd;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      seq_err_d     = 1'b0;
      store         = 1'b0;
      restart       = 1'b0;
      unique case (state_q)
         StSync: begin
            if (accept && idx == 2'd0) restart = 1'b1;
         end
         StCollect: begin
            if (accept) begin
               if (idx == nidx_q) begin
                  store = 1'b1;
               end else begin
                  seq_err_d = 1'b1;
                  restart   = (idx == 2'd0);
               end
            end
         end
         StEmit: begin
            bcd_d         = slots_q;
            frame_valid_d = 1'b1;
            frame_err_d   = err_q;
         end
         default: ;
      endcase
      // An out-of-order digit 0 starts a fresh frame in the same cycle.
      if (restart) begin
         slots_d[3:0] = nib;
         nidx_d       = 2'd1;
         err_d        = nib_bad;
      end
      if (store) begin
         slots_d[{idx, 2'b00} +: 4] = nib;
         nidx_d                     = nidx_q + 2'd1;
         err_d                      = err_q | nib_bad;
      end
   end

endmodule

// File: doc/seg_scan_reader.md
SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, is the number of consecutive identical samples required to accept a digit; legal range is 2..15.
REQ-002 Port: clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 Port: digit_en, input, 4 bits, one-hot active-high digit select from the display scanner; bit0 is units and bit3 is thousands.
REQ-005 Port: segments, input, 8 bits, active-low segment bus with bit0=a through bit6=g; bit7 is ignored.
REQ-006 Port: bcd, output, 16 bits, the last completed frame with one BCD nibble per digit; [3:0] is units and [15:12] is thousands.
REQ-007 Port: frame_valid, output, 1 bit, a 1-cycle pulse when bcd updates.
REQ-008 Port: frame_err, output, 1 bit, valid only with frame_valid; high if any digit in the frame had an invalid pattern.
REQ-009 Port: seq_err, output, 1 bit, a 1-cycle pulse when a digit is accepted out of scan order.

Function
REQ-010 segments and digit_en shall each pass through one input register before any other logic; all further references to "sample" mean this registered value.
REQ-011 The stability counter (4 bits) shall handle a changed {digit_en, segments[6:0]} sample as follows: the counter loads 1 and saturates at STABLE_CYCLES.
REQ-012 A digit shall be accepted on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES and digit_en is exactly one-hot; a held pattern yields only one acceptance.
REQ-013 A digit_en sample that is zero or multi-hot is blanking: the counter holds 0, no acceptance occurs, and the FSM state and the slots are unchanged.
REQ-014 Decoding of segments[6:0] on acceptance shall use this table: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9.
REQ-015 Any other segments[6:0] pattern shall store 4'hF in that digit's slot and set the frame's sticky error flag.
REQ-016 FSM state SYNC: only an accepted digit 0 is stored; it sets next index to 1, clears the error flag (then applies REQ-015 for this digit), and moves the FSM to COLLECT. Acceptances of other digits are ignored with no seq_err.
REQ-017 FSM state COLLECT: an accepted digit equal to the next index is stored and the next index increments.
REQ-018 In COLLECT, an accepted digit not equal to the next index shall pulse seq_err, discard the partial frame, and go to SYNC; if that digit is digit 0, it is processed as the first digit of a new frame in the same cycle.
REQ-019 On acceptance of digit 3 in COLLECT, the next edge shall update bcd with all four slots, pulse frame_valid, drive frame_err with the sticky flag, and return the FSM to SYNC.
REQ-020 Latency: frame_valid shall occur exactly STABLE_CYCLES+2 edges after digit 3's pattern first appears at the inputs.
REQ-021 bcd shall hold its value between frames; frame_err shall be 0 whenever frame_valid is 0.
REQ-022 seq_err and frame_valid shall never assert in the same cycle.

Reset
REQ-023 Asserting rst_n low shall immediately clear bcd, frame_valid, frame_err, seq_err, the input registers, the counter, the slots, the next index, and the error flag, and set the FSM to SYNC.
REQ-024 After rst_n deasserts, the first frame shall begin only at an accepted digit 0; a reset mid-frame discards the partial frame without pulsing any output.

Verification
REQ-025 Scan digit_en 0001/0010/0100/1000 with segments 0x30/0x24/0x79/0x12, each held 6 cycles -> frame_valid pulses once, bcd=16'h5123, frame_err=0.
REQ-026 Same scan with the digit 2 pattern 0x7F -> bcd=16'h5F23, frame_err=1.
REQ-027 Scan digit 0 then digit 2 (skip digit 1) -> seq_err pulses on the digit 2 acceptance, no frame_valid, and bcd keeps its previous value.
REQ-028 Digit pattern held only STABLE_CYCLES-1 cycles, or digit_en=0011 for 10 cycles -> no acceptance and no state change.
REQ-029 Pull rst_n low during digit 2 of a frame, then run a full valid scan of 0x40/0x00/0x10/0x78 -> the first frame_valid after reset shows bcd=16'h7980.
